fifo_ctrl_lookahead: RTL and testbench

//  Pointer/flag controller that drives the dual-read-port register file as a FWFT FIFO.
//  - Generates the write enable and write address for the file.
//  - Generates the head address (read port 1) and the head+1 lookahead address (read port 2).
//  - Keeps occupancy, threshold flags and sticky error flags.
//  - Sits between a producer/consumer pair and the register file inside a FIFO wrapper.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ctrl_lookahead.sv | 127 ++++++++++++
 tb/tb_fifo_ctrl_lookahead.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the look-ahead FIFO controller and its wrapper.
package fifo_pkg;

    // Encoding matches the {wr, rd} request pair so a cast decodes it directly.
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b10,
        OP_RW  = 2'b11
    } fifo_op_t;

    // Widest pointer the helper supports; callers cast in and out of it.
    localparam int unsigned PTR_MAX_W = 16;

    // Pointer increment; wrap-around comes from truncation at the caller.
    function automatic logic [PTR_MAX_W-1:0] succ(input logic [PTR_MAX_W-1:0] ptr);
        return ptr + PTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/fifo_ctrl_lookahead.sv
// Pointer/flag controller that runs a dual-read-port register file as a
// first-word-fall-through FIFO with a head+1 look-ahead read address.
module fifo_ctrl_lookahead
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  err_clr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr1,
    output logic [ADDR_WIDTH-1:0] r_addr2,
    output logic                  empty,
    output logic                  full,
    output logic                  peek_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] TWO_C   = ONE_C + ONE_C;
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    // Registered state
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  ovf, udf;

    // Next-state
    logic [ADDR_WIDTH-1:0] w_ptr_nxt, r_ptr_nxt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic                  ovf_nxt, udf_nxt;

    fifo_op_t op;
    logic     do_wr, do_rd;
    logic     set_ovf, set_udf;
    logic     is_empty, is_full;

    // Occupancy-based status; pointer equality is ambiguous when the file is full.
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DEPTH_C);

    // Decode the request pair against current occupancy and form next state.
    always_comb begin
        op        = fifo_op_t'({wr, rd});
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        set_ovf   = 1'b0;
        set_udf   = 1'b0;
        w_ptr_nxt = w_ptr;
        r_ptr_nxt = r_ptr;
        cnt_nxt   = cnt;

        case (op)
            OP_NOP: ;
            OP_WR: begin
                if (is_full) set_ovf = 1'b1;
                else         do_wr   = 1'b1;
            end
            OP_RD: begin
                if (is_empty) set_udf = 1'b1;
                else          do_rd   = 1'b1;
            end
            OP_RW: begin
                // Full: the slot being overwritten is the head, read out before the edge.
                // Empty: nothing to pop, so only the write lands.
                do_wr = 1'b1;
                if (is_empty) set_udf = 1'b1;
                else          do_rd   = 1'b1;
            end
            default: ;
        endcase

        if (do_wr) w_ptr_nxt = ADDR_WIDTH'(succ(PTR_MAX_W'(w_ptr)));
        if (do_rd) r_ptr_nxt = ADDR_WIDTH'(succ(PTR_MAX_W'(r_ptr)));

        if (do_wr && !do_rd)      cnt_nxt = cnt + ONE_C;
        else if (do_rd && !do_wr) cnt_nxt = cnt - ONE_C;

        // Clear wins over an error raised on the same edge.
        ovf_nxt = err_clr ? 1'b0 : (ovf | set_ovf);
        udf_nxt = err_clr ? 1'b0 : (udf | set_udf);
    end

    // Pointer, occupancy and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            w_ptr <= w_ptr_nxt;
            r_ptr <= r_ptr_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
            udf   <= udf_nxt;
        end
    end

    // Only wr_en depends on the live requests; every flag comes from registers.
    assign wr_en        = do_wr;
    assign w_addr       = w_ptr;
    assign r_addr1      = r_ptr;
    assign r_addr2      = ADDR_WIDTH'(succ(PTR_MAX_W'(r_ptr)));
    assign empty        = is_empty;
    assign full         = is_full;
    assign peek_valid   = (cnt >= TWO_C);
    assign count        = cnt;
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign overflow     = ovf;
    assign underflow    = udf;

endmodule

// File: tb/tb_fifo_ctrl_lookahead.sv
// Bench for fifo_ctrl_lookahead: a local register-file model plus a data
// scoreboard and an occupancy/pointer reference model.
module tb_fifo_ctrl_lookahead;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr, rd, err_clr;
    logic          wr_en;
    logic [AW-1:0] w_addr, r_addr1, r_addr2;
    logic          empty, full, peek_valid;
    logic [AW:0]   count;
    logic          almost_full, almost_empty, overflow, underflow;

    logic [7:0] wdata;
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] r_data1, r_data2;

    int tests  = 0;
    int failed = 0;

    // Reference model
    int m_count, m_wp, m_rp;
    bit m_ovf, m_udf;
    logic [7:0] sbq[$];

    fifo_ctrl_lookahead #(.ADDR_WIDTH(AW), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .err_clr(err_clr),
        .wr_en(wr_en), .w_addr(w_addr), .r_addr1(r_addr1), .r_addr2(r_addr2),
        .empty(empty), .full(full), .peek_valid(peek_valid), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Register file the controller is meant to drive.
    always @(posedge clk) if (wr_en) mem[w_addr] <= wdata;
    assign r_data1 = mem[r_addr1];
    assign r_data2 = mem[r_addr2];

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] data;
        int         cnt;
        logic       full, empty, af, ae, ovf, udf, pv;
        int         waddr, raddr1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
        sbq.delete();
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
        chk({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
        chk({tag, ".af"}, 32'(almost_full), 32'(m_count >= 3));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(m_count <= 1));
        chk({tag, ".pv"}, 32'(peek_valid), 32'(m_count >= 2));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".w_addr"}, 32'(w_addr), 32'(m_wp));
        chk({tag, ".r_addr1"}, 32'(r_addr1), 32'(m_rp));
        chk({tag, ".r_addr2"}, 32'(r_addr2), 32'((m_rp + 1) % DEPTH));
        if (m_count >= 1) chk({tag, ".r_data1"}, 32'(r_data1), 32'(sbq[0]));
        if (m_count >= 2) chk({tag, ".r_data2"}, 32'(r_data2), 32'(sbq[1]));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        bit acc_wr, acc_rd;
        logic [7:0] head;
        wr = w; rd = r; err_clr = c; wdata = d;
        #1;
        acc_rd = r && (m_count != 0);
        acc_wr = w && ((m_count != DEPTH) || r);
        chk("wr_en", 32'(wr_en), 32'(acc_wr));
        if (acc_rd) begin
            head = sbq.pop_front();
            chk("pop_data", 32'(r_data1), 32'(head));
        end
        if (acc_wr) sbq.push_back(d);
        m_ovf   = c ? 1'b0 : (m_ovf | (w && !r && m_count == DEPTH));
        m_udf   = c ? 1'b0 : (m_udf | (r && m_count == 0));
        m_count = m_count + int'(acc_wr) - int'(acc_rd);
        if (acc_wr) m_wp = (m_wp + 1) % DEPTH;
        if (acc_rd) m_rp = (m_rp + 1) % DEPTH;
        @(posedge clk);
        #1;
        wr = 0; rd = 0; err_clr = 0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [7:0] d,
                                input int cn, input logic fu, input logic em, input logic af,
                                input logic ae, input logic ov, input logic ud, input logic pv,
                                input int wa, input int ra);
        vec_t v;
        v.wr = w; v.rd = r; v.clr = c; v.data = d; v.cnt = cn; v.full = fu; v.empty = em;
        v.af = af; v.ae = ae; v.ovf = ov; v.udf = ud; v.pv = pv; v.waddr = wa; v.raddr1 = ra;
        return v;
    endfunction

    initial begin
        //           wr rd clr data   cnt full empty af ae ovf udf pv wa ra
        vecs.push_back(mk(1, 0, 0, 8'hA0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0)); // A
        vecs.push_back(mk(1, 0, 0, 8'hB0, 2, 0, 0, 0, 0, 0, 0, 1, 2, 0)); // B
        vecs.push_back(mk(1, 0, 0, 8'hC0, 3, 0, 0, 1, 0, 0, 0, 1, 3, 0)); // C
        vecs.push_back(mk(1, 0, 0, 8'hD0, 4, 1, 0, 1, 0, 0, 0, 1, 0, 0)); // D, full
        vecs.push_back(mk(1, 0, 0, 8'hEE, 4, 1, 0, 1, 0, 1, 0, 1, 0, 0)); // dropped
        vecs.push_back(mk(0, 0, 1, 8'h00, 4, 1, 0, 1, 0, 0, 0, 1, 0, 0)); // clear
        vecs.push_back(mk(1, 1, 0, 8'hE0, 4, 1, 0, 1, 0, 0, 0, 1, 1, 1)); // rd+wr full
        vecs.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 1, 0, 0, 0, 1, 1, 2)); // B
        vecs.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 1, 1, 3)); // C
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0)); // D
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1)); // E
        vecs.push_back(mk(1, 1, 0, 8'h5A, 1, 0, 0, 0, 1, 0, 1, 0, 2, 1)); // X on empty
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 2, 1)); // clear
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 2, 2)); // pop X
        vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 2, 2)); // clr beats udf

        reset_n = 0; wr = 0; rd = 0; err_clr = 0; wdata = '0;
        model_reset();
        @(negedge clk);
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.pv", 32'(peek_valid), 0);
        chk("rst.ae", 32'(almost_empty), 1);
        chk("rst.af", 32'(almost_full), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.udf", 32'(underflow), 0);
        chk("rst.w_addr", 32'(w_addr), 0);
        chk("rst.r_addr1", 32'(r_addr1), 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Table-driven sequence: fill, overflow, full rd+wr, drain, empty rd+wr.
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
            chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d.af", i), 32'(almost_full), 32'(vecs[i].af));
            chk($sformatf("v%0d.ae", i), 32'(almost_empty), 32'(vecs[i].ae));
            chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d.udf", i), 32'(underflow), 32'(vecs[i].udf));
            chk($sformatf("v%0d.pv", i), 32'(peek_valid), 32'(vecs[i].pv));
            chk($sformatf("v%0d.w_addr", i), 32'(w_addr), 32'(vecs[i].waddr));
            chk($sformatf("v%0d.r_addr1", i), 32'(r_addr1), 32'(vecs[i].raddr1));
            check_model($sformatf("v%0d", i));
            if (i == 11) chk("x_head", 32'(r_data1), 32'h5A);
        end

        // Two entries, look-ahead port, then 10 rd+wr ops walking the pointers round.
        step(1, 0, 0, 8'h51);
        step(1, 0, 0, 8'h52);
        check_model("fill2");
        chk("peek_data", 32'(r_data2), 32'h52);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 8'h60 + 8'(i));
            check_model($sformatf("wrap%0d", i));
        end
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        check_model("drain");

        // Random traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a 3-entry burst.
        step(0, 0, 1, 8'h00);
        while (m_count != 0) step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h71);
        step(1, 0, 0, 8'h72);
        wr = 1; wdata = 8'h73;
        #2;
        reset_n = 0;
        #1;
        chk("arst.empty", 32'(empty), 1);
        chk("arst.count", 32'(count), 0);
        chk("arst.w_addr", 32'(w_addr), 0);
        chk("arst.r_addr1", 32'(r_addr1), 0);
        chk("arst.full", 32'(full), 0);
        chk("arst.ae", 32'(almost_empty), 1);
        wr = 0;
        model_reset();
        @(negedge clk);
        reset_n = 1;
        check_model("post_rst");
        step(1, 0, 0, 8'h81);
        check_model("post_rst_wr");
        step(0, 1, 0, 8'h00);
        check_model("post_rst_rd");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1);
    end

endmodule
